// File: rtl/job_seq.sv
// job_seq: job sequencer for the z1 status block.
//
// Runs a JOB_LEN-cycle job when cmd_go is seen in IDLE. The job ends with
// exactly one of end / stop / error, and the result is then reported on
// status_code. A separate 5-stage delay line returns req as ack.
//
// State table
//   state | meaning
//   IDLE  | waiting for cmd_go
//   START | single start cycle; the run counter is cleared here
//   RUN   | job running; fault > cmd_abort > counter terminal count
//   TERM  | single cycle; one of endd/stop/er is high
//   COOL  | single cycle; status_valid is high with the latched result
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   cmd_go            job request; only looked at in IDLE
//   cmd_abort, fault  terminate requests; only looked at in RUN
//   req               input to the ack delay line
//   start, rt         high in START
//   enable            high in RUN, TERM and COOL
//   rdy               high in RUN and TERM
//   endd, stop, er    termination cause, high in TERM only
//   status_valid      high in COOL
//   status_code[1:0]  01 end, 10 stop, 11 error, 00 none
//   interrupt         high in the first RUN cycle and in COOL
//   ack               req delayed by 5 cycles
//   busy              high whenever the state is not IDLE
module job_seq #(
  parameter int JOB_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_go,
  input  logic       cmd_abort,
  input  logic       fault,
  input  logic       req,
  output logic       start,
  output logic       rt,
  output logic       enable,
  output logic       rdy,
  output logic       endd,
  output logic       stop,
  output logic       er,
  output logic       status_valid,
  output logic [1:0] status_code,
  output logic       interrupt,
  output logic       ack,
  output logic       busy
);

  localparam int CW = (JOB_LEN > 1) ? $clog2(JOB_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(JOB_LEN - 1);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_END  = 2'b01;
  localparam logic [1:0] RES_STOP = 2'b10;
  localparam logic [1:0] RES_ERR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_TERM,
    S_COOL
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    res, res_nx;
  logic [1:0]    code, code_nx;
  logic [4:0]    dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      res   <= RES_NONE;
      code  <= RES_NONE;
      dly   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      res   <= res_nx;
      code  <= code_nx;
      dly   <= {dly[3:0], req};
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    res_nx   = res;
    code_nx  = code;
    case (state)
      S_IDLE: begin
        if (cmd_go) begin
          state_nx = S_START;
          // the previous result stays visible until the next job starts
          code_nx  = RES_NONE;
        end
      end
      S_START: begin
        state_nx = S_RUN;
        cnt_nx   = '0;
      end
      S_RUN: begin
        if (fault) begin
          state_nx = S_TERM;
          res_nx   = RES_ERR;
        end else if (cmd_abort) begin
          state_nx = S_TERM;
          res_nx   = RES_STOP;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_TERM;
          res_nx   = RES_END;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_TERM: begin
        state_nx = S_COOL;
        code_nx  = res;
      end
      S_COOL:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs depend on registered state only. The counter is zero only in the
  // first RUN cycle, which gives the interrupt that covers the fall of start.
  always_comb begin
    start        = (state == S_START);
    rt           = (state == S_START);
    enable       = (state == S_RUN) || (state == S_TERM) || (state == S_COOL);
    rdy          = (state == S_RUN) || (state == S_TERM);
    endd         = (state == S_TERM) && (res == RES_END);
    stop         = (state == S_TERM) && (res == RES_STOP);
    er           = (state == S_TERM) && (res == RES_ERR);
    status_valid = (state == S_COOL);
    status_code  = code;
    interrupt    = ((state == S_RUN) && (cnt == '0)) || (state == S_COOL);
    ack          = dly[4];
    busy         = (state != S_IDLE);
  end

endmodule

// File: tb/tb_job_seq.sv
module tb_job_seq;

  localparam int JL = 8;

  logic clk = 1'b0;
  logic rst, cmd_go, cmd_abort, fault, req;
  logic start, rt, enable, rdy, endd, stop, er, status_valid;
  logic [1:0] status_code;
  logic interrupt, ack, busy;
  logic [12:0] obs;

  always #5 clk = ~clk;

  job_seq #(.JOB_LEN(JL)) dut (
    .clk(clk), .rst(rst), .cmd_go(cmd_go), .cmd_abort(cmd_abort),
    .fault(fault), .req(req), .start(start), .rt(rt), .enable(enable),
    .rdy(rdy), .endd(endd), .stop(stop), .er(er),
    .status_valid(status_valid), .status_code(status_code),
    .interrupt(interrupt), .ack(ack), .busy(busy)
  );

  assign obs = {start, rt, enable, rdy, endd, stop, er, status_valid,
                status_code, interrupt, ack, busy};

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: a job is described by the cycle of its START and the
  // cycle of its TERM; everything else is derived from those two times.
  int t_start = -1;
  int t_term = -1;
  logic [1:0] res_m = 2'b00;
  logic [1:0] code_m = 2'b00;
  bit req_h[16384];
  bit rst_h[16384];
  logic [12:0] exp_v;

  task automatic model_eval();
    int c;
    bit act, st, run, term, cool, ack_e;
    c = cyc;
    act = (t_start >= 0);
    st = act && (c == t_start);
    run = act && (c > t_start) && (c < t_term);
    term = act && (c == t_term);
    cool = act && (c == t_term + 1);
    ack_e = 1'b0;
    if (c >= 5 && req_h[c-5]) begin
      ack_e = 1'b1;
      for (int k = c - 5; k < c; k++) if (rst_h[k]) ack_e = 1'b0;
    end
    exp_v = {st, st, run | term | cool, run | term,
             term && res_m == 2'b01, term && res_m == 2'b10,
             term && res_m == 2'b11, cool, code_m,
             (act && c == t_start + 1) || cool, ack_e,
             act && c >= t_start && c <= t_term + 1};
  endtask

  task automatic model_update();
    int c;
    c = cyc;
    req_h[c] = req;
    rst_h[c] = rst;
    if (rst) begin
      t_start = -1;
      t_term = -1;
      code_m = 2'b00;
    end else begin
      if (t_start < 0 || c > t_term + 1) begin
        if (cmd_go) begin
          t_start = c + 1;
          t_term = c + 1 + JL + 1;
          res_m = 2'b01;
        end
      end else if (c > t_start && c < t_term) begin
        if (fault) begin
          t_term = c + 1;
          res_m = 2'b11;
        end else if (cmd_abort) begin
          t_term = c + 1;
          res_m = 2'b10;
        end
      end
      if (t_start >= 0) begin
        if (c + 1 == t_start) code_m = 2'b00;
        if (c + 1 == t_term + 1) code_m = res_m;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst = 1'b1;
      cmd_go = 1'($urandom);
      cmd_abort = 1'($urandom);
      fault = 1'($urandom);
      req = 1'($urandom);
      model_eval();
      if (i > 0) begin
        n_vec++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL reset c%0d outputs got %b want %b", i, obs, exp_v);
        end
        n_vec++;
        if (obs !== 13'd0) begin
          n_err++;
          $display("FAIL reset_zero c%0d outputs got %b want 0", i, obs);
        end
      end
      tick();
    end
    rst = 1'b0;
    cmd_go = 1'b0;
    cmd_abort = 1'b0;
    fault = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 14; i++) begin
      rst = 1'b0; cmd_go = (i == 0); cmd_abort = 1'b0; fault = 1'b0; req = 1'b0;
      model_eval();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL nominal c%0d outputs got %b want %b", i, obs, exp_v);
      end
      n_vec++;
      if (rdy !== (i >= 2 && i <= 10) || endd !== (i == 10) || start !== (i == 1)) begin
        n_err++;
        $display("FAIL nominal_seq c%0d rdy/endd/start got %b%b%b", i, rdy, endd, start);
      end
      if (i == 11) begin
        n_vec++;
        if (status_valid !== 1'b1 || status_code !== 2'b01 || interrupt !== 1'b1) begin
          n_err++;
          $display("FAIL nominal_status sv/code/int got %b/%b/%b want 1/01/1",
                   status_valid, status_code, interrupt);
        end
      end
      if (i == 12) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL nominal_idle busy got %b want 0", busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 14; i++) begin
      rst = 1'b0; cmd_go = (i == 0); cmd_abort = (i == 5); fault = 1'b0; req = 1'b0;
      model_eval();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL abort c%0d outputs got %b want %b", i, obs, exp_v);
      end
      n_vec++;
      if (stop !== (i == 6) || endd !== 1'b0) begin
        n_err++;
        $display("FAIL abort_stop c%0d stop/endd got %b/%b", i, stop, endd);
      end
      if (i == 7) begin
        n_vec++;
        if (rdy !== 1'b0 || status_code !== 2'b10) begin
          n_err++;
          $display("FAIL abort_status rdy/code got %b/%b want 0/10", rdy, status_code);
        end
      end
      tick();
    end
  endtask

  task automatic test_fault_last();
    for (int i = 0; i < 14; i++) begin
      rst = 1'b0; cmd_go = (i == 0); cmd_abort = (i == 9); fault = (i == 9); req = 1'b0;
      model_eval();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL fault_last c%0d outputs got %b want %b", i, obs, exp_v);
      end
      n_vec++;
      if (er !== (i == 10) || stop !== 1'b0 || endd !== 1'b0) begin
        n_err++;
        $display("FAIL fault_last_term c%0d er/stop/endd got %b/%b/%b", i, er, stop, endd);
      end
      if (i == 11) begin
        n_vec++;
        if (status_code !== 2'b11) begin
          n_err++;
          $display("FAIL fault_last_code got %b want 11", status_code);
        end
      end
      tick();
    end
  endtask

  task automatic test_go_held();
    for (int i = 0; i < 40; i++) begin
      rst = 1'b0; cmd_go = (i < 30); cmd_abort = 1'b0; fault = 1'b0; req = 1'b0;
      model_eval();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL go_held c%0d outputs got %b want %b", i, obs, exp_v);
      end
      n_vec++;
      if (start !== (i == 1 || i == 13 || i == 25)) begin
        n_err++;
        $display("FAIL go_held_start c%0d start got %b", i, start);
      end
      tick();
    end
  endtask

  task automatic test_ack();
    for (int i = 0; i < 15; i++) begin
      rst = 1'b0; cmd_go = 1'b0; cmd_abort = 1'b0; fault = 1'b0;
      req = (i == 0) || (i >= 3 && i <= 5);
      model_eval();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL ack c%0d outputs got %b want %b", i, obs, exp_v);
      end
      n_vec++;
      if (ack !== (i == 5 || (i >= 8 && i <= 10))) begin
        n_err++;
        $display("FAIL ack_delay c%0d ack got %b", i, ack);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      rst = (i == 6); cmd_go = (i == 0); cmd_abort = 1'b0; fault = 1'b0; req = (i == 3);
      model_eval();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid c%0d outputs got %b want %b", i, obs, exp_v);
      end
      if (i >= 7) begin
        n_vec++;
        if (obs !== 13'd0) begin
          n_err++;
          $display("FAIL reset_mid_zero c%0d outputs got %b want 0", i, obs);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cmd_go = ($urandom_range(0, 2) == 0);
      cmd_abort = ($urandom_range(0, 15) == 0);
      fault = ($urandom_range(0, 19) == 0);
      req = 1'($urandom);
      model_eval();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL random c%0d outputs got %b want %b", cyc, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_go = 1'b0; cmd_abort = 1'b0; fault = 1'b0; req = 1'b0;
    test_reset();
    test_nominal();
    test_abort();
    test_fault_last();
    test_go_held();
    test_ack();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/job_seq.md
# job_seq

Job sequencer that drives the start/run/terminate status handshake for the `z1` status block and its property checks. It runs a fixed-length job on command, terminates it with exactly one of end/stop/error, and reports a status code. It also includes an independent fixed 5-cycle request→acknowledge responder. The block is sized to satisfy the existing assertion set (p2, p3, p5–p10) by construction.

## Interface
- `JOB_LEN`, default 8: number of RUN cycles per job; legal range 2..255.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_go` in 1: job request; sampled only in IDLE.
- `cmd_abort` in 1: abort request; sampled only in RUN.
- `fault` in 1: error indication; sampled only in RUN.
- `req` in 1: request into the ack delay line.
- `start` out 1: high for the single START cycle.
- `rt` out 1: high for the single START cycle.
- `enable` out 1: high in RUN, TERM and COOL.
- `rdy` out 1: high in RUN and TERM.
- `endd` out 1: high in TERM when the job ran to completion.
- `stop` out 1: high in TERM when the job was aborted.
- `er` out 1: high in TERM when the job faulted.
- `status_valid` out 1: high in COOL.
- `status_code` out 2: job result; 01 end, 10 stop, 11 error, 00 none.
- `interrupt` out 1: high in the first RUN cycle and in COOL.
- `ack` out 1: `req` delayed by exactly 5 cycles.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, START, RUN, TERM, COOL. All outputs are decoded from registered state; no output depends combinationally on an input.
- IDLE:
  - `cmd_go` = 1 → START.
  - Otherwise stay in IDLE.
- START: unconditionally → RUN; clear the run counter to 0.
- RUN, evaluated each cycle in priority order:
  - `fault` = 1 → TERM, result = error.
  - else `cmd_abort` = 1 → TERM, result = stop.
  - else counter == JOB_LEN−1 → TERM, result = end.
  - else counter += 1, stay in RUN.
- Counter width is $clog2(JOB_LEN). The counter never wraps, because RUN always exits at JOB_LEN−1.
- TERM: exactly one of `endd`/`stop`/`er` is high, selected by the latched result; `rdy` = 1. Unconditionally → COOL.
- COOL:
  - `status_valid` = 1 and `status_code` = latched result.
  - `rdy` = 0, `start` = 0, `interrupt` = 1.
  - Unconditionally → IDLE.
- `status_code` holds its value through IDLE until the next START, where it clears to 00.
- Ignored inputs:
  - `cmd_go` outside IDLE.
  - `cmd_abort`/`fault` outside RUN.
  - `cmd_go` held high in COOL: it is taken on the first IDLE cycle, not in COOL.
- Ack line: 5-stage shift register; `ack`(t) = `req`(t−5). It is independent of the FSM and is updated in every state.
- Guarantees required by the property checks:
  - `er` never high for 2 consecutive cycles.
  - `er`&&`rdy` is never followed by `er`&&`rdy`.
  - The cycle after TERM always has `rdy` = 0.
  - `endd` is never coincident with `start` or `status_valid`.
  - `rt` = 1 implies `enable` = 0.
  - Every falling edge of `start` or `rdy` is accompanied by `interrupt` = 1.

## Timing
- Reset:
  - Next state = IDLE.
  - Every output = 0, including `status_code` = 00 and `ack` = 0.
  - All 5 ack stages cleared.
- Reset asserted mid-job or mid-delay-line: the next cycle shows all outputs 0. No TERM or COOL cycle is produced for the abandoned job.
- Nominal job, with `cmd_go` sampled high at edge 0:
  - START in cycle 1.
  - RUN in cycles 2..JOB_LEN+1.
  - TERM in cycle JOB_LEN+2.
  - COOL in cycle JOB_LEN+3.
  - IDLE in cycle JOB_LEN+4.
- Minimum go-to-go spacing is JOB_LEN+4 cycles.
- An abort or fault sampled in RUN cycle k gives TERM in cycle k+1 and COOL in cycle k+2.
- Abort or fault on the last RUN cycle overrides end.
- `fault` and `cmd_abort` high together → error.
- `ack` latency is exactly 5 cycles from `req` regardless of FSM state. A continuous `req` of N cycles gives a continuous `ack` of N cycles.

## Test plan
- Reset, then `cmd_go` pulse at edge 0, JOB_LEN=8 → `start`/`rt` high in c1; `rdy`/`enable` high in c2..c10; `interrupt` in c2; `endd` in c10; `status_valid`=1 with `status_code`=01 and `interrupt` in c11; `busy`=0 in c12.
- `cmd_abort` pulsed in the 4th RUN cycle (c5) → `stop` in c6, `rdy`=0 in c7, `status_code`=10; `endd` never asserted.
- `fault` and `cmd_abort` both high in c9 (the last RUN cycle) → `er` only in c10, `status_code`=11; `er` low in c11.
- `cmd_go` held high continuously → START recurs at c1, c13, c25 (12-cycle period); `cmd_go` is not acted on in TERM or COOL.
- `req` pulses at c0 and at c3..c5 → `ack` at c5 and at c8..c10 only.
- `rst` asserted in c6 of a running job → all outputs 0 from c7; no `endd`/`stop`/`er` or `status_valid` appears afterwards; a pending `ack` is suppressed.
